// File: rtl/uart_result_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// uart_result_sequencer_pkg
// Shared definitions for the matrix result sequencer: word width, default
// matrix geometry, ack-timeout default and the FSM state encoding.
// -----------------------------------------------------------------------------
package uart_result_sequencer_pkg;

    localparam int WORD_W     = 16;
    localparam int ROWS_DEF   = 4;
    localparam int COLS_DEF   = 4;
    localparam int ADDR_W_DEF = 4;
    localparam int ACK_TO_DEF = 8;

    // S_CSUM is only reachable when the checksum word is built in.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LAT   = 3'd2,
        S_START = 3'd3,
        S_ACK   = 3'd4,
        S_XMIT  = 3'd5,
        S_CSUM  = 3'd6,
        S_FIN   = 3'd7
    } seq_state_t;

endpackage

// File: rtl/uart_result_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_result_sequencer_if
// Bundles the result-RAM read port and the uart_tx word handshake.
//   mem_rd_en  : RAM read strobe            (sequencer -> RAM)
//   mem_addr   : RAM address                (sequencer -> RAM)
//   mem_rdata  : RAM data, 1 cycle latency  (RAM -> sequencer)
//   tx_data    : word for uart_tx           (sequencer -> uart_tx)
//   tx_start   : 1-cycle start pulse        (sequencer -> uart_tx)
//   tx_busy    : uart_tx busy               (uart_tx -> sequencer)
// master = sequencer side, slave = RAM/uart_tx side.
// -----------------------------------------------------------------------------
interface uart_result_sequencer_if #(
    parameter int ADDR_W = 4
);
    import uart_result_sequencer_pkg::*;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;

    modport master (
        output mem_rd_en, mem_addr, tx_data, tx_start,
        input  mem_rdata, tx_busy
    );

    modport slave (
        input  mem_rd_en, mem_addr, tx_data, tx_start,
        output mem_rdata, tx_busy
    );

endinterface

// File: rtl/uart_result_sequencer.sv
// -----------------------------------------------------------------------------
// uart_result_sequencer
// Streams a ROWS x COLS result buffer, row-major, through a 16-bit uart_tx
// word transmitter. Per word: read RAM, capture data, pulse tx_start, wait
// for tx_busy to rise then fall.
//
// Ports
//   i_clk     : system clock (shared with uart_tx)
//   i_rst     : synchronous reset, active high
//   i_go      : start streaming the whole matrix (accepted only in IDLE
//               with tx_busy low)
//   o_active  : high from go acceptance until done
//   o_done    : 1-cycle pulse at end of frame
//   o_err     : sticky ack timeout, cleared by reset or the next go
//   bus       : RAM read port + uart_tx handshake (master modport)
//
// Optional feature: define UART_SEQ_CHECKSUM_EN to append a 16-bit
// modulo-2^16 sum of all data words as an extra final word.
// -----------------------------------------------------------------------------
module uart_result_sequencer
    import uart_result_sequencer_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACK_TO = ACK_TO_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_go,
    output logic                    o_active,
    output logic                    o_done,
    output logic                    o_err,
    uart_result_sequencer_if.master bus
);

    localparam int                NWORDS   = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NWORDS - 1);
    localparam int                TO_W     = $clog2(ACK_TO + 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(ACK_TO - 1);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [WORD_W-1:0] r_tx_data;
    logic              r_tx_start;
    logic              r_rd_en;
    logic              r_active;
    logic              r_done;
    logic              r_err;
    logic [TO_W-1:0]   r_to_cnt;
`ifdef UART_SEQ_CHECKSUM_EN
    logic [WORD_W-1:0] r_csum;
    logic              r_csum_phase;   // set once the checksum word is in flight
`endif

    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_addr  = r_idx;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_start  = r_tx_start;
    assign o_active      = r_active;
    assign o_done        = r_done;
    assign o_err         = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_rd_en    <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_to_cnt   <= '0;
`ifdef UART_SEQ_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            // Strobes are asserted on entry to their state, so they last
            // exactly one cycle unless re-armed below.
            r_tx_start <= 1'b0;
            r_rd_en    <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_go && !bus.tx_busy) begin
                        r_state  <= S_RD;
                        r_rd_en  <= 1'b1;
                        r_active <= 1'b1;
                        r_err    <= 1'b0;
                        r_idx    <= '0;
`ifdef UART_SEQ_CHECKSUM_EN
                        r_csum       <= '0;
                        r_csum_phase <= 1'b0;
`endif
                    end
                end

                S_RD: r_state <= S_LAT;

                S_LAT: begin
                    r_tx_data  <= bus.mem_rdata;
`ifdef UART_SEQ_CHECKSUM_EN
                    r_csum     <= r_csum + bus.mem_rdata;
`endif
                    r_tx_start <= 1'b1;
                    r_state    <= S_START;
                end

                S_START: begin
                    r_to_cnt <= '0;
                    r_state  <= S_ACK;
                end

                S_ACK: begin
                    if (bus.tx_busy) begin
                        r_state <= S_XMIT;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= S_FIN;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_XMIT: begin
                    if (!bus.tx_busy) begin
`ifdef UART_SEQ_CHECKSUM_EN
                        if (r_csum_phase) begin
                            r_done   <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= S_FIN;
                        end else if (r_idx == LAST_IDX) begin
                            r_state <= S_CSUM;
                        end else begin
`else
                        if (r_idx == LAST_IDX) begin
                            r_done   <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= S_FIN;
                        end else begin
`endif
                            r_idx   <= r_idx + 1'b1;
                            r_rd_en <= 1'b1;
                            r_state <= S_RD;
                        end
                    end
                end

`ifdef UART_SEQ_CHECKSUM_EN
                // Plays the role of LAT for the trailing checksum word.
                S_CSUM: begin
                    r_tx_data    <= r_csum;
                    r_csum_phase <= 1'b1;
                    r_tx_start   <= 1'b1;
                    r_state      <= S_START;
                end
`endif

                S_FIN: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_sequencer.sv
module tb_uart_result_sequencer;
    import uart_result_sequencer_pkg::*;

`ifdef UART_SEQ_CHECKSUM_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic active, done, err;

    int checks = 0;
    int errors = 0;

    uart_result_sequencer_if #(.ADDR_W(2)) bus();

    uart_result_sequencer #(
        .ROWS(2), .COLS(2), .ADDR_W(2), .ACK_TO(8)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_go(go),
        .o_active(active), .o_done(done), .o_err(err),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, data valid the cycle after mem_rd_en.
    logic [15:0] ram [0:3];
    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];

    // uart_tx model: busy for busy_len cycles after start; mute ignores start.
    int   busy_len = 18;
    logic mute      = 1'b0;
    logic hold_busy = 1'b0;
    logic m_busy;
    int   m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (bus.tx_start && !mute) begin
            m_busy <= 1'b1;
            m_cnt  <= busy_len;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end
    end
    assign bus.tx_busy = m_busy | hold_busy;

    // Monitor: words handed to uart_tx and done pulses.
    logic [15:0] q[$];
    int done_cnt = 0;
    always @(posedge clk) begin
        if (!rst && bus.tx_start) q.push_back(bus.tx_data);
        if (!rst && done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1'b1);
        chk({tag, "_active"}, active, 1'b0);
    endtask

    int n;

    initial begin
        ram[0] = 16'h0001; ram[1] = 16'h0002; ram[2] = 16'h0003; ram[3] = 16'h0004;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---- 2x2 stream, latency, inter-word gap, go ignored while active
        q.delete(); done_cnt = 0;
        pulse_go();
        chk("t1_active", active, 1);
        chk("t1_rd_en", bus.mem_rd_en, 1);
        chk("t1_addr0", bus.mem_addr, 0);
        chk("t1_nostart_rd", bus.tx_start, 0);
        @(negedge clk);
        chk("t1_nostart_lat", bus.tx_start, 0);
        chk("t1_rd_en_off", bus.mem_rd_en, 0);
        @(negedge clk);
        chk("t1_start_lat4", bus.tx_start, 1);
        chk("t1_data0", bus.tx_data, 16'h0001);
        n = 0;
        while (bus.tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("t1_busy_rise", bus.tx_busy, 1);
        n = 0;
        while (bus.tx_busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        chk("t1_busy_fall", bus.tx_busy, 0);
        pulse_go();   // sampled while in XMIT: must be ignored
        chk("t1_addr1", bus.mem_addr, 1);
        chk("t1_rd_en1", bus.mem_rd_en, 1);
        @(negedge clk);
        chk("t1_gap_nostart", bus.tx_start, 0);
        @(negedge clk);
        chk("t1_gap_start", bus.tx_start, 1);
        chk("t1_data1_hold", bus.tx_data, 16'h0002);
        wait_done("t1_done", 300);
        @(negedge clk);
        chk("t1_nwords", q.size(), NW);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_word%0d", i), (q.size() > i) ? q[i] : 16'hdead, i + 1);
`ifdef UART_SEQ_CHECKSUM_EN
        chk("t1_csum", (q.size() > 4) ? q[4] : 16'hdead, 16'h000A);
`endif
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_pulse", done, 0);

        // ---- go while tx_busy=1 in IDLE is ignored
        q.delete();
        hold_busy = 1'b1;
        pulse_go();
        repeat (4) @(negedge clk);
        chk("t5_idle_busy_active", active, 0);
        chk("t5_idle_busy_nostart", q.size(), 0);
        chk("t5_idle_busy_rd", bus.mem_rd_en, 0);
        hold_busy = 1'b0;
        @(negedge clk);

        // ---- ack timeout
        q.delete(); done_cnt = 0;
        mute = 1'b1;
        pulse_go();
        n = 0;
        while (bus.tx_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("t3_start", bus.tx_start, 1);
        repeat (8) @(negedge clk);
        chk("t3_err_early", err, 0);
        chk("t3_active_early", active, 1);
        @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_done", done, 1);
        chk("t3_active", active, 0);
        @(negedge clk);
        chk("t3_err_sticky", err, 1);
        chk("t3_done_once", done, 0);
        mute = 1'b0;
        q.delete();
        pulse_go();
        chk("t3_err_cleared", err, 0);
        chk("t3_reactive", active, 1);
        wait_done("t3_redone", 300);
        chk("t3_nwords", q.size(), NW);

        // ---- reset during XMIT of word 2
        @(negedge clk);
        q.delete();
        pulse_go();
        n = 0;
        while (!(q.size() == 2 && bus.tx_busy === 1'b1) && n < 200) begin @(negedge clk); n++; end
        chk("t4_word2_busy", bus.tx_busy, 1);
        @(negedge clk);   // now in XMIT
        rst = 1'b1;
        @(negedge clk);
        chk("t4_active", active, 0);
        chk("t4_done", done, 0);
        chk("t4_err", err, 0);
        chk("t4_tx_start", bus.tx_start, 0);
        chk("t4_rd_en", bus.mem_rd_en, 0);
        chk("t4_addr", bus.mem_addr, 0);
        chk("t4_tx_data", bus.tx_data, 0);
        rst = 1'b0;
        @(negedge clk);
        q.delete();
        pulse_go();
        chk("t4_restart_addr", bus.mem_addr, 0);
        chk("t4_restart_rd", bus.mem_rd_en, 1);
        wait_done("t4_done_restart", 300);
        chk("t4_nwords", q.size(), NW);
        chk("t4_first", (q.size() > 0) ? q[0] : 16'hdead, 16'h0001);

        // ---- wrap-around checksum data
        ram[0] = 16'hFFFF; ram[1] = 16'h0002; ram[2] = 16'h0000; ram[3] = 16'h0001;
        @(negedge clk);
        q.delete();
        pulse_go();
        wait_done("t6_done", 300);
        chk("t6_nwords", q.size(), NW);
        chk("t6_word0", (q.size() > 0) ? q[0] : 16'hdead, 16'hFFFF);
        chk("t6_word3", (q.size() > 3) ? q[3] : 16'hdead, 16'h0001);
`ifdef UART_SEQ_CHECKSUM_EN
        chk("t6_csum", (q.size() > 4) ? q[4] : 16'hdead, 16'h0002);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
